// File: rtl/rom_load_ctrl.sv
// ============================================================================
// Module   : rom_load_ctrl
// Purpose  : ioctl ROM download sequencer with a 2-entry FIFO and a core reset
//            hold. ROMLOAD_CKSUM_EN adds a 16-bit checksum check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_load_ctrl #(
    parameter int ROM_INDEX = 0,
    parameter int ROM_AW    = 17,
    parameter int ROM_SIZE  = 'h1_8000,
    parameter int HOLD_CYC  = 16
`ifdef ROMLOAD_CKSUM_EN
    ,
    parameter logic [15:0] ROM_CKSUM = 16'h0000
`endif
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              rom_we,
    input  logic              rom_ready,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [ROM_AW:0]   byte_cnt
`ifdef ROMLOAD_CKSUM_EN
    ,
    output logic [15:0]       cksum
`endif
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_HOLD  = 3'd3,
        S_RUN   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t            r_state;
    logic [HW-1:0]     r_hold;
    logic              r_sel_d;

    logic [ROM_AW-1:0] r_fifo_addr [2];
    logic [7:0]        r_fifo_data [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;

`ifdef ROMLOAD_CKSUM_EN
    logic [15:0]       r_cksum;
`endif

    logic w_sel, w_rise, w_fall, w_enter;
    logic w_pop, w_push, w_try, w_in_range, w_err_evt, w_empty_next, w_good;

    assign w_sel   = ioctl_download & (ioctl_index == 8'(ROM_INDEX));
    assign w_rise  = w_sel & ~r_sel_d;
    assign w_fall  = ~w_sel & r_sel_d;
    assign w_enter = w_rise & ((r_state == S_IDLE) | (r_state == S_RUN) | (r_state == S_ERR));

    assign rom_we     = (r_count != 2'd0);
    assign ioctl_wait = (r_count == 2'd2);
    assign rom_addr   = r_fifo_addr[r_rptr];
    assign rom_data   = r_fifo_data[r_rptr];

    assign w_pop      = rom_we & rom_ready;
    assign w_in_range = (ioctl_addr < 25'(ROM_SIZE));
    assign w_try      = (r_state == S_LOAD) & ioctl_wr;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign w_push     = w_try & w_in_range & (~ioctl_wait | w_pop);
    assign w_err_evt  = w_try & (~w_in_range | (ioctl_wait & ~w_pop));
    assign w_empty_next = (r_count == 2'd0) | ((r_count == 2'd1) & w_pop);

`ifdef ROMLOAD_CKSUM_EN
    assign cksum  = r_cksum;
    assign w_good = (byte_cnt == (ROM_AW + 1)'(ROM_SIZE)) & ~load_err & (r_cksum == ROM_CKSUM);
`else
    assign w_good = (byte_cnt == (ROM_AW + 1)'(ROM_SIZE)) & ~load_err;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_fifo_addr[0] <= '0;
            r_fifo_addr[1] <= '0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_wptr         <= 1'b0;
            r_rptr         <= 1'b0;
            r_count        <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wptr] <= ioctl_addr[ROM_AW-1:0];
                r_fifo_data[r_wptr] <= ioctl_dout;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // sel_d resets high so a download already running at reset release is ignored.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sel_d    <= 1'b1;
            r_state    <= S_IDLE;
            r_hold     <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            byte_cnt   <= '0;
`ifdef ROMLOAD_CKSUM_EN
            r_cksum    <= 16'h0000;
`endif
        end else begin
            r_sel_d <= w_sel;
            case (r_state)
                S_IDLE, S_RUN, S_ERR: begin
                    if (w_rise) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_fall) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_empty_next) begin
                        r_state <= S_HOLD;
                        r_hold  <= HW'(HOLD_CYC - 1);
                    end
                end
                S_HOLD: begin
                    if (r_hold == '0) begin
                        if (w_good) begin
                            r_state    <= S_RUN;
                            core_reset <= 1'b0;
                            load_done  <= 1'b1;
                        end else begin
                            r_state  <= S_ERR;
                            load_err <= 1'b1;
                        end
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_enter) begin
                byte_cnt   <= '0;
                load_err   <= 1'b0;
                load_done  <= 1'b0;
                core_reset <= 1'b1;
`ifdef ROMLOAD_CKSUM_EN
                r_cksum    <= 16'h0000;
`endif
            end else begin
                if (w_pop && !(&byte_cnt)) begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
`ifdef ROMLOAD_CKSUM_EN
                if (w_pop) begin
                    r_cksum <= r_cksum + {8'h00, rom_data};
                end
`endif
                if (w_err_evt) begin
                    load_err <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rom_load_ctrl.sv
// ============================================================================
// Module   : tb_rom_load_ctrl
// Purpose  : randomized directed bench for rom_load_ctrl with a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_load_ctrl;

    localparam int AW   = 6;
`ifdef ROMLOAD_CKSUM_EN
    localparam int SIZE = 16;
`else
    localparam int SIZE = 48;
`endif
    localparam int HOLD = 16;
    localparam int SAT  = (1 << (AW + 1)) - 1;
    localparam logic [15:0] CK = 16'h0088;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          ioctl_download = 1'b0;
    logic [7:0]    ioctl_index = 8'd0;
    logic          ioctl_wr = 1'b0;
    logic [24:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_dout = '0;
    logic          ioctl_wait;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          rom_we;
    logic          rom_ready = 1'b1;
    logic          core_reset;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   byte_cnt;
`ifdef ROMLOAD_CKSUM_EN
    logic [15:0]   cksum;
`endif

    rom_load_ctrl #(
        .ROM_INDEX (0),
        .ROM_AW    (AW),
        .ROM_SIZE  (SIZE),
        .HOLD_CYC  (HOLD)
`ifdef ROMLOAD_CKSUM_EN
        ,
        .ROM_CKSUM (CK)
`endif
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_we         (rom_we),
        .rom_ready      (rom_ready),
        .core_reset     (core_reset),
        .load_done      (load_done),
        .load_err       (load_err),
        .byte_cnt       (byte_cnt)
`ifdef ROMLOAD_CKSUM_EN
        ,
        .cksum          (cksum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } ent_t;

    // Reference model: accepted bytes in order, plus load-level bookkeeping.
    ent_t        q[$];
    int          m_cnt;
    bit          m_err;
    bit          m_ok;
    int          m_phase;   // 0 idle, 1 loading, 2 draining/holding, 3 finished
    int          m_hold;
    bit          m_seld;
    logic [15:0] m_sum;
    int          cyc;
    int          last_pop_cyc;
    int          fall_cyc;
    logic        prev_cr;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt   = 0;
        m_err   = 1'b0;
        m_ok    = 1'b0;
        m_phase = 0;
        m_hold  = -1;
        m_seld  = 1'b1;
        m_sum   = 16'h0000;
        prev_cr = 1'b1;
    endtask

    task automatic check_outputs();
        chk("rom_we", 32'(rom_we), 32'(q.size() != 0));
        chk("ioctl_wait", 32'(ioctl_wait), 32'(q.size() == 2));
        chk("byte_cnt", 32'(byte_cnt), 32'(m_cnt));
        chk("load_err", 32'(load_err), 32'(m_err));
        chk("load_done", 32'(load_done), 32'(m_phase == 3 && m_ok));
        chk("core_reset", 32'(core_reset), 32'(!(m_phase == 3 && m_ok)));
        if (q.size() != 0) begin
            chk("rom_addr", 32'(rom_addr), 32'(q[0].a));
            chk("rom_data", 32'(rom_data), 32'(q[0].d));
        end
`ifdef ROMLOAD_CKSUM_EN
        chk("cksum", 32'(cksum), 32'(m_sum));
`endif
    endtask

    // One clock: drive, check against the model, advance DUT and model.
    task automatic tick(input logic wr, input logic [24:0] a, input logic [7:0] d);
        bit   sel, pop, push, fin;
        int   p0;
        ent_t e;
        ioctl_wr   = wr;
        ioctl_addr = a;
        ioctl_dout = d;
        #1;
        check_outputs();
        if (prev_cr && !core_reset) fall_cyc = cyc;
        prev_cr = core_reset;

        sel  = ioctl_download && (ioctl_index == 8'd0);
        pop  = (q.size() != 0) && rom_ready;
        push = 1'b0;
        p0   = m_phase;
        if (p0 == 1 && wr) begin
            if (a >= 25'(SIZE)) m_err = 1'b1;
            else if (q.size() < 2 || pop) push = 1'b1;
            else m_err = 1'b1;
        end

        @(posedge clk_sys);
        cyc++;
        if (pop) begin
            e = q.pop_front();
            if (m_cnt < SAT) m_cnt++;
            m_sum = m_sum + {8'h00, e.d};
            last_pop_cyc = cyc;
        end
        if (push) begin
            e.a = a[AW-1:0];
            e.d = d;
            q.push_back(e);
        end
        fin = 1'b0;
        if (p0 == 2) begin
            if (m_hold < 0) begin
                if (q.size() == 0) m_hold = HOLD;
            end else begin
                m_hold--;
                if (m_hold == 0) fin = 1'b1;
            end
        end
        if (fin) begin
            m_ok = (m_cnt == SIZE) && !m_err;
`ifdef ROMLOAD_CKSUM_EN
            m_ok = m_ok && (m_sum == CK);
`endif
            if (!m_ok) m_err = 1'b1;
            m_phase = 3;
        end
        if (sel && !m_seld && (p0 == 0 || p0 == 3)) begin
            m_phase = 1;
            m_cnt   = 0;
            m_err   = 1'b0;
            m_ok    = 1'b0;
            m_sum   = 16'h0000;
        end else if (!sel && m_seld && p0 == 1) begin
            m_phase = 2;
            m_hold  = -1;
        end
        m_seld = sel;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic start_load();
        ioctl_download = 1'b1;
        tick(1'b0, '0, '0);
    endtask

    task automatic finish_load();
        rom_ready      = 1'b1;
        ioctl_download = 1'b0;
        repeat (HOLD + 8) tick(1'b0, '0, '0);
    endtask

    task automatic load_image(input int n);
        rom_ready = 1'b1;
        start_load();
        for (int i = 0; i < n; i++) tick(1'b1, 25'(i), 8'(i + 1));
        finish_load();
    endtask

    initial begin
        int addr;
        cyc = 0;
        last_pop_cyc = 0;
        fall_cyc = 0;
        model_reset();
        repeat (3) @(negedge clk_sys);
        #1;
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_rom_we", 32'(rom_we), 32'd0);
        chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        tick(1'b0, '0, '0);

        // Nominal image; last two bytes held back so the final pop lands in drain.
        start_load();
        for (int i = 0; i < SIZE; i++) begin
            if (i == SIZE - 1) rom_ready = 1'b0;
`ifdef ROMLOAD_CKSUM_EN
            tick(1'b1, 25'(i), 8'(i + 1));
`else
            tick(1'b1, 25'(i), 8'($urandom));
`endif
        end
        chk("nom_wait_full", 32'(ioctl_wait), 32'd1);
        ioctl_download = 1'b0;
        repeat (3) tick(1'b0, '0, '0);
        finish_load();
        chk("nom_done", 32'(load_done), 32'd1);
        chk("nom_err", 32'(load_err), 32'd0);
        chk("nom_cnt", 32'(byte_cnt), 32'(SIZE));
        chk("nom_release_lat", 32'(fall_cyc - last_pop_cyc), 32'(HOLD));

        // Backpressure with a source that honours ioctl_wait.
        start_load();
        addr = 0;
        for (int it = 0; it < 600 && addr < SIZE; it++) begin
            logic w;
            rom_ready = (it < 5) ? 1'b0 : ($urandom_range(0, 3) != 0);
            w = !ioctl_wait && ($urandom_range(0, 4) != 0 || it < 5);
            tick(w, 25'(addr), 8'($urandom));
            if (w) addr++;
        end
        chk("bp_sent", 32'(addr), 32'(SIZE));
        finish_load();
        chk("bp_cnt", 32'(byte_cnt), 32'(SIZE));

        // Overflow: third write into a stalled full FIFO.
        rom_ready = 1'b0;
        start_load();
        for (int i = 0; i < 3; i++) tick(1'b1, 25'(i), 8'($urandom));
        chk("ovf_err_now", 32'(load_err), 32'd1);
        finish_load();
        chk("ovf_cnt", 32'(byte_cnt), 32'd2);
        chk("ovf_core_reset", 32'(core_reset), 32'd1);

        // Short image.
        load_image(SIZE - 1);
        chk("short_cnt", 32'(byte_cnt), 32'(SIZE - 1));
        chk("short_err", 32'(load_err), 32'd1);
        chk("short_done", 32'(load_done), 32'd0);

        // Full image plus out-of-range writes at ROM_SIZE and the top address.
        rom_ready = 1'b1;
        start_load();
        for (int i = 0; i < SIZE; i++) tick(1'b1, 25'(i), 8'($urandom));
        tick(1'b1, 25'(SIZE), 8'h5A);
        chk("oor_err_now", 32'(load_err), 32'd1);
        tick(1'b1, 25'h1FF_FFFF, 8'hA5);
        finish_load();
        chk("oor_cnt", 32'(byte_cnt), 32'(SIZE));
        chk("oor_core_reset", 32'(core_reset), 32'd1);

        // Counter saturation through repeated in-range addresses.
        start_load();
        for (int i = 0; i < SAT + 6; i++) tick(1'b1, 25'(i % SIZE), 8'($urandom));
        finish_load();
        chk("sat_cnt", 32'(byte_cnt), 32'(SAT));

        // Wrong index: everything ignored.
        ioctl_index = 8'd1;
        start_load();
        for (int i = 0; i < 10; i++) tick(1'b1, 25'(i), 8'($urandom));
        finish_load();
        chk("widx_cnt", 32'(byte_cnt), 32'(SAT));
        chk("widx_err", 32'(load_err), 32'd1);
        ioctl_index = 8'd0;

        // Reset mid-load, then a download still active at release is ignored.
        rom_ready = 1'b0;
        start_load();
        tick(1'b1, 25'd0, 8'h11);
        tick(1'b1, 25'd1, 8'h22);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_mid_wait", 32'(ioctl_wait), 32'd0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        rom_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick(1'b1, 25'(i), 8'($urandom));
        chk("rst_ignored_cnt", 32'(byte_cnt), 32'd0);
        ioctl_download = 1'b0;
        tick(1'b0, '0, '0);
        load_image(SIZE);
        chk("fresh_done", 32'(load_done), 32'd1);
        chk("fresh_core_reset", 32'(core_reset), 32'd0);
`ifdef ROMLOAD_CKSUM_EN
        chk("fresh_cksum", 32'(cksum), 32'h0088);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
